// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//   Multi-cycle WIDTH-bit subtractor: z = x - y - b_in, SLICE bits per clock,
//   LSB slice first, borrow carried between slices in a flop.
//   start/ready/done handshake; result registers hold until the next accept.
//   Optional feature macro: SUB_OVERFLOW_EN adds the signed-overflow output ovf.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready=1, waiting for start; operands latched on accept
//   ST_RUN  | one slice per cycle, cnt selects the slice being written
//   ST_DONE | one cycle, done pulse is high, then back to ST_IDLE
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             b_out,
  output logic             zero
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             brw;
  // Operands are shifted right by one slice per RUN cycle, so the active
  // slice is always in the low bits.
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [SLICE:0]   diff;
  logic [WIDTH-1:0] z_upd;
  logic             last;

`ifdef SUB_OVERFLOW_EN
  logic             x_msb;
  logic             y_msb;
`endif

  assign last = (cnt == CW'(NSLICE - 1));

  // Slice difference with borrow; the extra MSB of diff is the borrow out.
  always_comb begin
    diff  = {1'b0, x_sh[SLICE-1:0]} - {1'b0, y_sh[SLICE-1:0]} - {{SLICE{1'b0}}, brw};
    z_upd = z;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        z_upd[k*SLICE +: SLICE] = diff[SLICE-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready = (state == ST_IDLE);
  end

  // Datapath: operand latch, slice-by-slice result, final flags and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      brw   <= 1'b0;
      x_sh  <= '0;
      y_sh  <= '0;
      z     <= '0;
      b_out <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_sh <= x;
            y_sh <= y;
            brw  <= b_in;
            cnt  <= '0;
`ifdef SUB_OVERFLOW_EN
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          z    <= z_upd;
          brw  <= diff[SLICE];
          x_sh <= x_sh >> SLICE;
          y_sh <= y_sh >> SLICE;
          cnt  <= last ? '0 : cnt + 1'b1;
          if (last) begin
            b_out <= diff[SLICE];
            zero  <= (z_upd == '0);
            done  <= 1'b1;
`ifdef SUB_OVERFLOW_EN
            ovf   <= (x_msb != y_msb) && (z_upd[WIDTH-1] != x_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: stimulus pushes expected
// results from an arithmetic reference model; a monitor pops on done.
module tb_nibble_serial_subtractor;

  localparam int W      = 16;
  localparam int NSLICE = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         ready;
  logic         done;
  logic [W-1:0] z;
  logic         b_out;
  logic         zero;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  nibble_serial_subtractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .z     (z),
    .b_out (b_out),
    .zero  (zero)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] z;
    logic         bo;
    logic         zr;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer subtraction, wrapped modulo 2^W.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    int   d;
    d    = int'(a) - int'(b) - int'(bi);
    e.z  = W'(d);
    e.bo = (d < 0);
    e.zr = (e.z == '0);
    e.ov = (a[W-1] != b[W-1]) && (e.z[W-1] != a[W-1]);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compare each done pulse against the oldest expectation,
  // then confirm the pulse is single-cycle and the result holds.
  initial begin
    exp_t e;
    bit   hold_chk = 0;
    forever begin
      @(negedge clk);
      if (hold_chk) begin
        hold_chk = 0;
        chk("done_one_cycle", done, 0);
        chk("hold_z", z, e.z);
        chk("hold_b_out", b_out, e.bo);
      end else if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          e = q.pop_front();
          chk("z", z, e.z);
          chk("b_out", b_out, e.bo);
          chk("zero", zero, e.zr);
          chk("latency", cyc - e.acc, NSLICE);
`ifdef SUB_OVERFLOW_EN
          chk("ovf", ovf, e.ov);
`endif
          hold_chk = 1;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    wait_ready();
    x = a; y = b; b_in = bi; start = 1'b1;
    e = model(a, b, bi);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    x = $urandom; y = $urandom; b_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int acc_prev;
    int accepts;
    int n;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_z", z, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_zero", zero, 0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", ovf, 0);
`endif

    // Directed cases.
    do_op(16'h1234, 16'h0234, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0);
    do_op(16'h5555, 16'h5554, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0);
    drain();

    // Start pulsed during RUN with different operands must be ignored.
    do_op(16'hA5A5, 16'h1111, 1'b1);
    @(negedge clk);
    chk("busy_ready", ready, 0);
    x = 16'hFFFF; y = 16'h0000; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high: a new operation at every IDLE, NSLICE+2 apart.
    start = 1'b1;
    accepts = 0; acc_prev = 0; n = 0;
    while (accepts < 3 && n < 60) begin
      if (ready) begin
        exp_t e;
        x = pick(); y = pick(); b_in = 1'($urandom_range(0, 1));
        e = model(x, y, b_in);
        e.acc = cyc + 1;
        q.push_back(e);
        if (accepts > 0) chk("b2b_spacing", e.acc - acc_prev, NSLICE + 2);
        acc_prev = e.acc;
        accepts++;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("b2b_accepts", accepts, 3);
    drain();

    // Reset two cycles into RUN aborts the operation.
    do_op(16'h4321, 16'h1234, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done", done, 0);
    chk("abort_z", z, 0);
    chk("abort_b_out", b_out, 0);
    chk("abort_zero", zero, 0);
    chk("abort_ready", ready, 1);
    repeat (NSLICE + 3) @(negedge clk);
    do_op(16'h0100, 16'h0001, 1'b0);
    drain();

    // rst and start together: start is dropped.
    rst = 1'b1; start = 1'b1; x = 16'h1111; y = 16'h2222;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_dropped", ready, 1);
    repeat (NSLICE + 3) @(negedge clk);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      do_op(pick(), pick(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
